fft_host_stream_bridge: RTL and testbench
=========================================

Name: fft_host_stream_bridge

Overview:
Host-side initiator for the FFT accelerator top.
- Deserialises a narrow valid/ready sample stream into the wide data_in and data_in_fmem buses.
- Drives mode_application and ce_fft, waits for out_valid and finish_fft_process, captures data_out.
- Serialises the captured result back out as a valid/ready stream.
- Sits between the system interconnect/DMA and the accelerator.

Parameters:
- size, 128, FFT points per frame (power of two, >=2)
- width, 24, bits per sample lane
- bus_width, size*width, accelerator bus width
- timeout, 4096, max cycles from launch to finish_fft_process; 0 disables the watchdog

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- cfg_mode  in  4  mode_application for next frame; sampled on first accepted sample
- cfg_use_fmem  in  1  1: frame carries 2*size samples (second half -> data_in_fmem); sampled with cfg_mode
- s_valid  in  1  input sample valid
- s_ready  out  1  bridge accepts sample
- s_data  in  width  input sample
- mode_application  out  4  to accelerator
- ce_fft  out  1  to accelerator
- data_in  out  bus_width  to accelerator
- data_in_fmem  out  bus_width  to accelerator
- data_out  in  bus_width  from accelerator
- out_valid  in  1  from accelerator
- finish_fft_process  in  1  from accelerator
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_data  out  width  output sample
- m_last  out  1  last sample of frame
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; cleared by the first accepted sample of the next frame
- err_noresult  out  1  sticky; cleared by the first accepted sample of the next frame

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; data_in, data_in_fmem, result buffer, m_data = 0; mode_application=0. Outputs s_ready=0 during reset, then 1 in IDLE; ce_fft, m_valid, m_last, busy, err_* = 0. Reset mid-frame discards everything; no partial handshakes survive.
- Lane mapping: sample k goes to bits [k*width +: width]. Output sample j = result[j*width +: width].
- States: IDLE, LOAD_D, LOAD_F, LAUNCH, WAIT, DRAIN.
- IDLE: s_ready=1. On s_valid&&s_ready:
  - latch cfg_mode->mode_application and cfg_use_fmem;
  - write lane 0; idx=1; clear err_*;
  - go LOAD_D.
- LOAD_D: s_ready=1. Each handshake writes lane idx and increments idx.
  - After lane size-1: idx=0; go LOAD_F if use_fmem, else LAUNCH.
- LOAD_F: same lane fill into data_in_fmem; after lane size-1, go LAUNCH.
- s_ready=0 in LAUNCH, WAIT, DRAIN. No sample is accepted or dropped while s_ready=0.
- LAUNCH (1 cycle): ce_fft rises the next cycle; wdog=0; go WAIT.
- WAIT:
  - ce_fft=1 continuously.
  - data_in, data_in_fmem, mode_application stay stable until the WAIT exit.
  - First cycle with out_valid=1: capture data_out into the result buffer; set got=1. Later out_valid pulses in the same frame are ignored.
  - finish_fft_process=1 with got=1, or with out_valid=1 in the same cycle (capture that cycle): ce_fft=0 next cycle; go DRAIN.
  - finish_fft_process=1 with no capture: err_noresult=1; go IDLE.
  - wdog increments each WAIT cycle. timeout!=0 and wdog==timeout-1 without finish: err_timeout=1, ce_fft=0; go IDLE. Finish takes priority over timeout in the same cycle.
- DRAIN:
  - m_valid=1; m_data=lane odx; m_last=(odx==size-1).
  - m_data is registered; the first valid word appears the cycle after entry. m_valid and m_data hold stable while m_ready=0.
  - On m_valid&&m_ready: odx++. On the last handshake: m_valid=0, odx=0; go IDLE.
- Throughput: one sample per cycle in and out under continuous valid/ready.
- Frame latency: input last handshake -> ce_fft high = 2 cycles.

Test Plan:
- Basic frame: size=128, cfg_mode=4, use_fmem=0, s_data=k, model returns out_valid+finish 10 cycles after ce_fft with data_out lane j = j+1000.
  - Required: ce_fft high 2 cycles after the 128th handshake; m_data = 1000..1127; m_last only on 1127; busy falls after the last handshake.
- fmem frame: use_fmem=1, 256 samples.
  - Required: data_in lanes 0..127, data_in_fmem lanes = samples 128..255; s_ready=0 after 256.
- Backpressure: random s_valid gaps and m_ready toggling 50%.
  - Required: no loss or duplication; m_data is stable while m_ready=0; output order preserved.
- Timeout: timeout=64, model never finishes.
  - Required: err_timeout=1 and ce_fft=0 at 64 cycles after entering WAIT; state IDLE; next frame clears err_timeout.
- No result: finish_fft_process without out_valid.
  - Required: err_noresult=1; m_valid never asserted.
- out_valid and finish in the same cycle: result captured, normal drain.
- Reset mid-DRAIN at odx=50: all outputs return to reset values asynchronously; after release, s_ready=1 and m_valid=0.

Source files
------------

// File: rtl/fft_host_stream_bridge.sv
// Host-side initiator for the FFT accelerator: packs a narrow sample stream into the wide
// accelerator buses, runs one transform, and streams the captured result back out.
module fft_host_stream_bridge #(
    parameter int size      = 128,
    parameter int width     = 24,
    parameter int bus_width = size*width,
    parameter int timeout   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cfg_mode,
    input  logic                 cfg_use_fmem,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [width-1:0]     s_data,
    output logic [3:0]           mode_application,
    output logic                 ce_fft,
    output logic [bus_width-1:0] data_in,
    output logic [bus_width-1:0] data_in_fmem,
    input  logic [bus_width-1:0] data_out,
    input  logic                 out_valid,
    input  logic                 finish_fft_process,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [width-1:0]     m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_noresult
);
    localparam int IW = (size > 1) ? $clog2(size) : 1;
    localparam int WW = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(size - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'((timeout > 0) ? timeout - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_F, LAUNCH, WAIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [size-1:0][width-1:0] din_q, fmem_q, res_q;
    logic [IW-1:0] idx, odx;
    logic [WW-1:0] wdog;
    logic          use_fmem, got;

    logic s_hs, m_hs, idx_last, odx_last, wd_expire, fin_ok;

    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign idx_last  = (idx == IDX_LAST);
    assign odx_last  = (odx == IDX_LAST);
    assign wd_expire = (timeout != 0) && (wdog == WD_LAST);
    // A finish in the same cycle as the first out_valid still counts as a result.
    assign fin_ok    = finish_fft_process && (got || out_valid);

    assign data_in      = din_q;
    assign data_in_fmem = fmem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (s_hs) state_nxt = LOAD_D;
            LOAD_D: if (s_hs && idx_last) state_nxt = use_fmem ? LOAD_F : LAUNCH;
            LOAD_F: if (s_hs && idx_last) state_nxt = LAUNCH;
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (finish_fft_process) state_nxt = fin_ok ? DRAIN : IDLE;
                else if (wd_expire)     state_nxt = IDLE;
            end
            DRAIN:  if (m_hs && odx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // s_ready is gated by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        s_ready = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE, LOAD_D, LOAD_F: s_ready = rst;
            default:              s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q            <= '0;
            fmem_q           <= '0;
            res_q            <= '0;
            idx              <= '0;
            odx              <= '0;
            wdog             <= '0;
            use_fmem         <= 1'b0;
            got              <= 1'b0;
            mode_application <= 4'd0;
            ce_fft           <= 1'b0;
            m_valid          <= 1'b0;
            m_data           <= '0;
            m_last           <= 1'b0;
            err_timeout      <= 1'b0;
            err_noresult     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        mode_application <= cfg_mode;
                        use_fmem         <= cfg_use_fmem;
                        din_q[0]         <= s_data;
                        idx              <= IW'(1);
                        err_timeout      <= 1'b0;
                        err_noresult     <= 1'b0;
                    end
                end
                LOAD_D: begin
                    if (s_hs) begin
                        din_q[idx] <= s_data;
                        idx        <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                LOAD_F: begin
                    if (s_hs) begin
                        fmem_q[idx] <= s_data;
                        idx         <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                LAUNCH: begin
                    ce_fft <= 1'b1;
                    wdog   <= '0;
                    got    <= 1'b0;
                end
                WAIT: begin
                    if (out_valid && !got) begin
                        res_q <= data_out;
                        got   <= 1'b1;
                    end
                    // Finish wins over the watchdog when both land in the same cycle.
                    if (finish_fft_process) begin
                        ce_fft <= 1'b0;
                        if (!fin_ok) err_noresult <= 1'b1;
                    end else if (wd_expire) begin
                        ce_fft      <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= res_q[odx];
                        m_last  <= odx_last;
                    end else if (m_ready) begin
                        if (odx_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            odx     <= '0;
                        end else begin
                            odx     <= odx + 1'b1;
                            m_data  <= res_q[odx + 1'b1];
                            m_last  <= ((odx + 1'b1) == IDX_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_host_stream_bridge.sv
// Directed bench for fft_host_stream_bridge with a small accelerator model and an output scoreboard.
module tb_fft_host_stream_bridge;
    localparam int SIZE = 128;
    localparam int W    = 24;
    localparam int BW   = SIZE*W;
    localparam int TO   = 64;

    logic          clk, rst;
    logic [3:0]    cfg_mode;
    logic          cfg_use_fmem;
    logic          s_valid, s_ready;
    logic [W-1:0]  s_data;
    logic [3:0]    mode_application;
    logic          ce_fft;
    logic [BW-1:0] data_in, data_in_fmem, data_out;
    logic          out_valid, finish_fft_process;
    logic          m_valid, m_ready;
    logic [W-1:0]  m_data;
    logic          m_last, busy, err_timeout, err_noresult;

    fft_host_stream_bridge #(.size(SIZE), .width(W), .bus_width(BW), .timeout(TO)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_use_fmem(cfg_use_fmem),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mode_application(mode_application), .ce_fft(ce_fft),
        .data_in(data_in), .data_in_fmem(data_in_fmem), .data_out(data_out),
        .out_valid(out_valid), .finish_fft_process(finish_fft_process),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout), .err_noresult(err_noresult)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     fails  = 0;
    logic   mon_en = 1'b0, rand_ready = 1'b0, hold_empty = 1'b0;
    logic   prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    // Accelerator model: 0 = out_valid+finish together, 1 = never finishes,
    // 2 = finish without result, 3 = early result, ignored second pulse, late finish.
    int acc_mode = 0;
    int acc_base = 0;
    int acc_cnt  = 0;

    function automatic logic [BW-1:0] make_out(input int base);
        logic [BW-1:0] v;
        v = '0;
        for (int j = 0; j < SIZE; j++) v[j*W +: W] = W'(base + j);
        return v;
    endfunction

    always @(negedge clk) begin
        out_valid          = 1'b0;
        finish_fft_process = 1'b0;
        if (!ce_fft) acc_cnt = 0;
        else begin
            acc_cnt++;
            case (acc_mode)
                0: if (acc_cnt == 10) begin
                       data_out = make_out(acc_base); out_valid = 1'b1; finish_fft_process = 1'b1;
                   end
                2: if (acc_cnt == 10) finish_fft_process = 1'b1;
                3: begin
                       if (acc_cnt == 4) begin data_out = make_out(acc_base); out_valid = 1'b1; end
                       if (acc_cnt == 7) begin data_out = make_out(acc_base + 5000); out_valid = 1'b1; end
                       if (acc_cnt == 10) finish_fft_process = 1'b1;
                   end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int base, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back('{d: W'(base + j), last: (j == SIZE-1)});
    endtask

    task automatic send(input logic [W-1:0] d, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("s_ready_wait", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // cfg_* is scrambled after the first sample to prove it is latched only once.
    task automatic send_frame(input logic [3:0] mode, input logic fm, input int first, input int maxgap);
        int n;
        n = fm ? 2*SIZE : SIZE;
        cfg_mode = mode;
        cfg_use_fmem = fm;
        for (int k = 0; k < n; k++) begin
            send(W'(first + k), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (k == 0) begin cfg_mode = ~mode; cfg_use_fmem = ~fm; end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        check(tag, (n < 3000), 1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; cfg_mode = 4'd0; cfg_use_fmem = 1'b0;
        m_ready = 1'b0; data_out = '0;
        #1 rst = 1'b0;
        #3;
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ce", ce_fft, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_err", {err_timeout, err_noresult}, 0);
        check("rst_mode", mode_application, 0);
        check("rst_din", |data_in, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("idle_s_ready", s_ready, 1);
        mon_en = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!mon_en) begin
                    m_ready = 1'b0;
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        check("m_hold_valid", m_valid, 1);
                        check("m_hold_data", m_data, prev_data);
                    end
                    if (hold_empty && exp_q.size() == 0) m_ready = 1'b0;
                    else m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) check("m_extra", m_valid, 0);
                        else begin
                            mon_e = exp_q.pop_front();
                            check("m_data", m_data, mon_e.d);
                            check("m_last", m_last, mon_e.last);
                        end
                    end
                    prev_stall = m_valid && !m_ready;
                    prev_data  = m_data;
                end
            end
        join_none

        // Basic frame, out_valid and finish in the same cycle.
        @(negedge clk);
        acc_mode = 0; acc_base = 1000;
        push_exp(1000, SIZE);
        send_frame(4'd4, 1'b0, 0, 0);
        check("launch_ce_low", ce_fft, 0);
        check("launch_s_ready", s_ready, 0);
        @(negedge clk);
        check("lat_ce_high", ce_fft, 1);
        check("mode_latched", mode_application, 4);
        for (int k = 0; k < SIZE; k++) check("din_lane", data_in[k*W +: W], 64'(k));
        check("fmem_untouched", |data_in_fmem, 0);
        wait_idle("basic_done");
        @(negedge clk);
        check("basic_busy", busy, 0);
        check("basic_m_valid", m_valid, 0);
        check("basic_err", {err_timeout, err_noresult}, 0);

        // fmem frame with input gaps and output backpressure.
        acc_base = 2000; rand_ready = 1'b1;
        push_exp(2000, SIZE);
        send_frame(4'd2, 1'b1, 500, 2);
        check("fmem_s_ready", s_ready, 0);
        check("fmem_mode", mode_application, 2);
        for (int k = 0; k < SIZE; k++) begin
            check("fmem_din", data_in[k*W +: W], 64'(500 + k));
            check("fmem_lane", data_in_fmem[k*W +: W], 64'(500 + SIZE + k));
        end
        wait_idle("fmem_done");
        rand_ready = 1'b0;

        // Watchdog: model never finishes.
        acc_mode = 1;
        send_frame(4'd7, 1'b0, 9000, 0);
        repeat (64) @(negedge clk);
        check("to_early_err", err_timeout, 0);
        check("to_early_ce", ce_fft, 1);
        @(negedge clk);
        check("to_err", err_timeout, 1);
        check("to_ce", ce_fft, 0);
        check("to_busy", busy, 0);
        check("to_s_ready", s_ready, 1);
        check("to_m_valid", m_valid, 0);

        // Finish without a result; the monitor flags any m_valid.
        acc_mode = 2;
        send_frame(4'd1, 1'b0, 100, 0);
        check("nr_err_to_cleared", err_timeout, 0);
        wait_idle("nr_done");
        check("nr_err", err_noresult, 1);
        check("nr_ce", ce_fft, 0);

        // Early result, later out_valid pulse must be ignored.
        acc_mode = 3; acc_base = 3000;
        push_exp(3000, SIZE);
        send_frame(4'd9, 1'b0, 200, 1);
        check("ov_err_nr_cleared", err_noresult, 0);
        wait_idle("ov_done");
        check("ov_err", {err_timeout, err_noresult}, 0);

        // Reset while draining, stalled at odx=50.
        acc_mode = 0; acc_base = 4000; hold_empty = 1'b1;
        push_exp(4000, 50);
        send_frame(4'd3, 1'b0, 300, 0);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
            check("rd_reach50", (n < 1000), 1);
        end
        repeat (3) @(negedge clk);
        check("rd_stall_valid", m_valid, 1);
        check("rd_stall_data", m_data, 4050);
        check("rd_busy", busy, 1);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rd_m_valid", m_valid, 0);
        check("rd_m_data", m_data, 0);
        check("rd_m_last", m_last, 0);
        check("rd_s_ready", s_ready, 0);
        check("rd_busy0", busy, 0);
        check("rd_ce", ce_fft, 0);
        check("rd_mode", mode_application, 0);
        check("rd_din", |data_in, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rd_rel_s_ready", s_ready, 1);
        check("rd_rel_m_valid", m_valid, 0);
        hold_empty = 1'b0; mon_en = 1'b1;

        // Recovery frame after reset: output restarts from lane 0.
        acc_base = 5000;
        @(negedge clk);
        push_exp(5000, SIZE);
        send_frame(4'd5, 1'b0, 700, 0);
        wait_idle("rec_done");
        check("rec_err", {err_timeout, err_noresult}, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
